reservation_station: RTL
========================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of station entries (2..8).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port dispatch_valid  input  1  dispatch request.
REQ-005 SHALL have port dispatch_ready  output  1  station can accept.
REQ-006 SHALL have port dispatch_op  input  6  ALU opcode.
REQ-007 SHALL have port dispatch_dest  input  6  ROB tag of the result.
REQ-008 SHALL have ports src_data1, src_data2  input  33 each  operand: bit32=1 means [31:0] holds a value; bit32=0 means [5:0] holds the producer ROB tag.
REQ-009 SHALL have ports cdb1, cdb2  input  38 each  broadcast: [37:32] tag, [31:0] data; tag 6'd0 means idle.
REQ-010 SHALL have port issue_valid  output  1  an entry is ready to issue.
REQ-011 SHALL have port issue_ready  input  1  execution unit accepts.
REQ-012 SHALL have ports issue_op  output  6, issue_dest  output  6, issue_data1  output  32, issue_data2  output  32, all fields of the selected entry.
REQ-013 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-014 SHALL have port count  output  4  number of valid entries.

Function
REQ-015 SHALL store each entry as {op, dest, s1[32:0], s2[32:0]} in a collapsing queue: slots 0..count-1 valid, slot 0 oldest.
REQ-016 SHALL drive dispatch_ready = (count < ENTRIES); a dispatch fires when dispatch_valid && dispatch_ready, otherwise inputs are ignored.
REQ-017 SHALL write a fired dispatch into slot count, or slot count-1 when an issue fires in the same cycle.
REQ-018 SHALL, each cycle, for every valid operand with bit32=0 (including one being dispatched), compare [5:0] against cdb1[37:32] and cdb2[37:32] when the CDB tag is nonzero, and on match register {1'b1, cdb data}.
REQ-019 SHALL give cdb1 priority over cdb2 when both match the same operand.
REQ-020 SHALL treat an entry as ready when s1[32]=1 and s2[32]=1 in the registered state; wakeup captured at edge N makes the entry eligible in the cycle after edge N, with no combinational CDB-to-issue bypass.
REQ-021 SHALL drive issue_valid = 1 when any valid entry is ready, presenting the lowest-index (oldest) ready entry on the issue_* outputs combinationally from registers.
REQ-022 SHALL, when issue_valid && issue_ready, remove the selected slot k and shift slots k+1..count-1 down by one at the edge, applying wakeup to the shifted contents.
REQ-023 SHALL recompute the selection every cycle, so issue_* may change while issue_valid=1 and issue_ready=0.
REQ-024 SHALL update count as count + dispatch_fire - issue_fire, which never exceeds ENTRIES and never underflows.
REQ-025 SHALL, on flush=1, set count=0 and invalidate all entries at the next edge, overriding any same-cycle dispatch or issue; the issue handshake in that cycle is not counted as fired.
REQ-026 SHALL drive issue_* data outputs to 0 when issue_valid=0.

Reset
REQ-027 SHALL, while rst=1 and independent of clk, force count=0, all entries invalid and all stored fields 0, issue_valid=0, issue_* =0, and dispatch_ready=1.
REQ-028 SHALL, on reset asserted mid-operation, discard all in-flight entries with no issue fire reported in that cycle.

Verification
REQ-029 SHALL pass this test: dispatch op=3, dest=9, src1={1,5}, src2={1,7} with issue_ready=1 -> next cycle issue_valid=1, op 3, dest 9, data 5/7; count returns to 0 after the fire.
REQ-030 SHALL pass this test: dispatch src1 tag 12 (bit32=0) with src2 ready; next cycle cdb2={12,32'hDEAD_BEEF} -> issue_valid=1 one cycle later with issue_data1=32'hDEAD_BEEF.
REQ-031 SHALL pass this test: 4 dispatches with unready operands -> count=4, dispatch_ready=0; a 5th dispatch_valid is ignored and count stays 4.
REQ-032 SHALL pass this test: entries A (slot 0) and B (slot 2) both ready, issue_ready=1 -> A issues first, B issues the next cycle, and the unready slot 1 shifts to slot 0.
REQ-033 SHALL pass this test: cdb1={20,32'h1} and cdb2={20,32'h2} in the same cycle for a waiting tag 20 -> captured value 32'h1; then flush with count=3 -> count=0 and issue_valid=0 next cycle.
REQ-034 SHALL pass this test: rst pulse between clock edges with count=2 -> count=0, issue_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: operands wake up from two CDB ports,
// and the oldest entry with both operands ready is offered to the execution unit.
module reservation_station #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dispatch_valid,
  output logic        dispatch_ready,
  input  logic [5:0]  dispatch_op,
  input  logic [5:0]  dispatch_dest,
  input  logic [32:0] src_data1,
  input  logic [32:0] src_data2,
  input  logic [37:0] cdb1,
  input  logic [37:0] cdb2,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [5:0]  issue_op,
  output logic [5:0]  issue_dest,
  output logic [31:0] issue_data1,
  output logic [31:0] issue_data2,
  input  logic        flush,
  output logic [3:0]  count
);

  localparam int unsigned CW   = 4;
  localparam int unsigned TW   = 6;
  localparam int unsigned DW   = 32;
  localparam int unsigned OW   = DW + 1;
  localparam int unsigned CDBW = TW + DW;

  typedef struct packed {
    logic [TW-1:0] op;
    logic [TW-1:0] dest;
    logic [OW-1:0] s1;
    logic [OW-1:0] s2;
  } rs_entry_t;

  rs_entry_t     r_ent  [ENTRIES];
  rs_entry_t     w_next [ENTRIES];
  rs_entry_t     w_sel_ent;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_sel;
  logic [CW-1:0] w_wr;
  logic          w_issue_valid;
  logic          w_issue_fire;
  logic          w_dispatch_fire;

  // Capture a broadcast result into a waiting operand; cdb1 wins a double match.
  function automatic logic [OW-1:0] wake(input logic [OW-1:0] s,
                                         input logic [CDBW-1:0] c1,
                                         input logic [CDBW-1:0] c2);
    logic [OW-1:0] r;
    r = s;
    if (!s[OW-1]) begin
      if (c1[CDBW-1:DW] != '0 && c1[CDBW-1:DW] == s[TW-1:0]) begin
        r = {1'b1, c1[DW-1:0]};
      end else if (c2[CDBW-1:DW] != '0 && c2[CDBW-1:DW] == s[TW-1:0]) begin
        r = {1'b1, c2[DW-1:0]};
      end
    end
    return r;
  endfunction

  function automatic rs_entry_t wake_ent(input rs_entry_t e,
                                         input logic [CDBW-1:0] c1,
                                         input logic [CDBW-1:0] c2);
    rs_entry_t r;
    r    = e;
    r.s1 = wake(e.s1, c1, c2);
    r.s2 = wake(e.s2, c1, c2);
    return r;
  endfunction

  // Oldest-ready select: scan downward so the lowest index is left standing.
  always_comb begin : select
    w_issue_valid = 1'b0;
    w_sel         = '0;
    w_sel_ent     = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (CW'(i) < r_count && r_ent[i].s1[OW-1] && r_ent[i].s2[OW-1]) begin
        w_issue_valid = 1'b1;
        w_sel         = CW'(i);
        w_sel_ent     = r_ent[i];
      end
    end
  end

  assign dispatch_ready  = r_count < CW'(ENTRIES);
  assign w_issue_fire    = w_issue_valid && issue_ready && !flush;
  assign w_dispatch_fire = dispatch_valid && dispatch_ready && !flush;
  assign w_wr            = r_count - CW'(w_issue_fire);
  assign w_count_next    = r_count + CW'(w_dispatch_fire) - CW'(w_issue_fire);

  // Collapse over the issued slot, wake everything, then append the dispatch.
  always_comb begin : next_state
    for (int i = 0; i < int'(ENTRIES); i++) begin
      w_next[i] = '0;
      if (w_issue_fire && CW'(i) >= w_sel) begin
        if (i + 1 < int'(ENTRIES) && CW'(i + 1) < r_count) begin
          w_next[i] = wake_ent(r_ent[(i + 1) % int'(ENTRIES)], cdb1, cdb2);
        end
      end else if (CW'(i) < r_count) begin
        w_next[i] = wake_ent(r_ent[i], cdb1, cdb2);
      end
      if (w_dispatch_fire && CW'(i) == w_wr) begin
        w_next[i] = {dispatch_op, dispatch_dest,
                     wake(src_data1, cdb1, cdb2), wake(src_data2, cdb1, cdb2)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) r_ent[i] <= '0;
    end else if (flush) begin
      r_count <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) r_ent[i] <= '0;
    end else begin
      r_count <= w_count_next;
      for (int i = 0; i < int'(ENTRIES); i++) r_ent[i] <= w_next[i];
    end
  end

  assign issue_valid = w_issue_valid;
  assign issue_op    = w_sel_ent.op;
  assign issue_dest  = w_sel_ent.dest;
  assign issue_data1 = w_sel_ent.s1[DW-1:0];
  assign issue_data2 = w_sel_ent.s2[DW-1:0];
  assign count       = r_count;

endmodule
